// File: rtl/uart_pkg.sv
// uart_pkg -- definitions shared by the UART transmitter and receiver.
//   uart_state_t : frame state encoding (IDLE/START/DATA/STOP)
//   SPEED_W      : width of the bit-period (speed) value in clk cycles
//   MIN_SPEED    : smallest bit period accepted by a speed update
//   RESET_SPEED  : bit period in effect after reset
package uart_pkg;

    localparam int SPEED_W = 13;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam logic [SPEED_W-1:0] MIN_SPEED   = 13'd16;
    localparam logic [SPEED_W-1:0] RESET_SPEED = 13'h1869;

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo -- small byte queue in front of the transmitter.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   push, din  : enqueue din; ignored while full
//   pop, dout  : dequeue; dout always shows the head entry
//   count      : number of stored entries (0..DEPTH)
//   full/empty : derived from the registered count
module uart_tx_fifo #(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [7:0]    din,
    output logic [7:0]    dout,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    // full comes from the registered count, so a pop in the same cycle
    // does not open a slot for a write that arrives while full.
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (do_pop && !do_push)
                count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// uart_tx -- 8N1 UART transmitter with a byte queue and runtime bit period.
//   clk, reset       : rising-edge clock, synchronous active-high reset
//   speed, set_speed : strobe a new bit period (clk cycles); values < 16 ignored
//   data_in, wr_en   : enqueue one byte; dropped while full
//   full             : queue holds FIFO_DEPTH bytes
//   busy             : frame in progress or bytes still queued
//   tx               : registered serial output, idle high
//   tx_done          : one-cycle pulse during the last cycle of each stop bit
module uart_tx #(
    parameter int           FIFO_DEPTH  = 4,
    parameter logic [12:0]  RESET_SPEED = uart_pkg::RESET_SPEED
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [12:0] speed,
    input  logic        set_speed,
    input  logic [7:0]  data_in,
    input  logic        wr_en,
    output logic        full,
    output logic        busy,
    output logic        tx,
    output logic        tx_done
);
    import uart_pkg::*;

    localparam int AW = $clog2(FIFO_DEPTH);

    uart_state_t        state;
    logic [12:0]        period_reg;   // programmed bit period
    logic [12:0]        per_lat;      // period frozen for the current frame
    logic [12:0]        cnt;          // cycles elapsed in the current bit
    logic [2:0]         bit_idx;
    logic [7:0]         shreg;        // remaining data bits, LSB goes out next
    logic [7:0]         head;
    logic [AW:0]        fifo_count;
    logic               empty;
    logic               last;
    logic               pop;

    assign last = (cnt == per_lat - 13'd1);

    // Pop when a new frame starts: from IDLE, or at the last stop cycle
    // so the next start bit follows without a gap.
    assign pop = !empty && ((state == IDLE) || (state == STOP && last));

    assign busy = (state != IDLE) || (fifo_count != '0);

    uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (wr_en),
        .pop   (pop),
        .din   (data_in),
        .dout  (head),
        .count (fifo_count),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            tx         <= 1'b1;
            tx_done    <= 1'b0;
            period_reg <= RESET_SPEED;
            per_lat    <= RESET_SPEED;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
        end else begin
            tx_done <= 1'b0;
            if (set_speed && speed >= MIN_SPEED)
                period_reg <= speed;

            case (state)
                IDLE: begin
                    if (!empty) begin
                        state   <= START;
                        tx      <= 1'b0;
                        shreg   <= head;
                        per_lat <= period_reg;
                        cnt     <= '0;
                    end
                end
                START: begin
                    if (last) begin
                        state   <= DATA;
                        tx      <= shreg[0];
                        shreg   <= shreg >> 1;
                        bit_idx <= '0;
                        cnt     <= '0;
                    end else begin
                        cnt <= cnt + 13'd1;
                    end
                end
                DATA: begin
                    if (last) begin
                        cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                            tx    <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= shreg[0];
                            shreg   <= shreg >> 1;
                        end
                    end else begin
                        cnt <= cnt + 13'd1;
                    end
                end
                STOP: begin
                    // Registered pulse: set one edge early so it is visible
                    // exactly during the final stop cycle.
                    if (cnt == per_lat - 13'd2)
                        tx_done <= 1'b1;
                    if (last) begin
                        cnt <= '0;
                        if (!empty) begin
                            state   <= START;
                            tx      <= 1'b0;
                            shreg   <= head;
                            per_lat <= period_reg;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + 13'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx -- directed self-checking bench for uart_tx.
module tb_uart_tx;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [12:0] speed = '0;
    logic        set_speed = 1'b0;
    logic [7:0]  data_in = '0;
    logic        wr_en = 1'b0;
    logic        full;
    logic        busy;
    logic        tx;
    logic        tx_done;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_tx #(.FIFO_DEPTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .speed     (speed),
        .set_speed (set_speed),
        .data_in   (data_in),
        .wr_en     (wr_en),
        .full      (full),
        .busy      (busy),
        .tx        (tx),
        .tx_done   (tx_done)
    );

    initial begin
        #3_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Walks a frame cycle by cycle starting at cycle 'skip' of the start bit.
    // Each bit must hold its value for exactly 'per' samples; tx_done must be
    // high only in the final cycle of the stop bit.
    task automatic check_frame(input logic [7:0] b, input int per, input int nbits,
                               input int skip, input int exp_full, input string tag);
        int dbad;
        int fbad;
        dbad = 0;
        fbad = 0;
        for (int k = 0; k < nbits; k++) begin
            logic e;
            int   bad;
            bad = 0;
            e = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
            for (int c = (k == 0 ? skip : 0); c < per; c++) begin
                if (tx !== e) bad++;
                if (tx_done !== (k == 9 && c == per - 1)) dbad++;
                if (exp_full >= 0 && full !== exp_full[0]) fbad++;
                tick;
            end
            check($sformatf("%s_bit%0d", tag, k), bad, 0);
        end
        check($sformatf("%s_txdone", tag), dbad, 0);
        if (exp_full >= 0)
            check($sformatf("%s_full", tag), fbad, 0);
    endtask

    // Reference receiver: finds a start bit, samples mid-bit.
    task automatic rx_byte(input int per, output logic [7:0] b, output logic ok);
        int  n;
        logic st;
        n = 0;
        b = '0;
        while (tx !== 1'b0 && n < 20 * per) begin
            tick;
            n++;
        end
        if (tx !== 1'b0) begin
            ok = 1'b0;
            return;
        end
        repeat (per / 2) tick;
        st = (tx === 1'b0);
        for (int i = 0; i < 8; i++) begin
            repeat (per) tick;
            b[i] = tx;
        end
        repeat (per) tick;
        ok = st && (tx === 1'b1);
    endtask

    initial begin
        logic [7:0] burst [6];
        logic [7:0] lb [3];
        logic [7:0] rb;
        logic       rok;
        int         bad;
        int         inbound;

        burst[0] = 8'h11; burst[1] = 8'h22; burst[2] = 8'h33;
        burst[3] = 8'h44; burst[4] = 8'h55; burst[5] = 8'h66;
        lb[0] = 8'h00; lb[1] = 8'hFF; lb[2] = 8'h55;

        // Reset state
        reset = 1'b1;
        repeat (3) tick;
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_full", full, 0);
        check("rst_txdone", tx_done, 0);
        reset = 1'b0;
        tick;

        // Single byte 0xA5 at 16 cycles/bit, 2-edge latency to start bit
        speed = 13'd16; set_speed = 1'b1; tick; set_speed = 1'b0;
        data_in = 8'hA5; wr_en = 1'b1; tick; wr_en = 1'b0;
        check("lat_edge0_tx", tx, 1);
        check("lat_edge0_busy", busy, 1);
        tick;
        check("lat_edge1_tx", tx, 0);
        check_frame(8'hA5, 16, 10, 0, -1, "a5");
        check("a5_after_busy", busy, 0);
        check("a5_after_tx", tx, 1);

        // Six consecutive writes: five fit, sixth dropped, frames back to back
        for (int i = 0; i < 6; i++) begin
            data_in = burst[i]; wr_en = 1'b1; tick;
            check($sformatf("burst_full_w%0d", i + 1), full, (i >= 4) ? 1 : 0);
        end
        wr_en = 1'b0;
        check_frame(burst[0], 16, 10, 4, 1, "burst0");
        check("burst_full_after_pop", full, 0);
        for (int i = 1; i < 5; i++)
            check_frame(burst[i], 16, 10, 0, -1, $sformatf("burst%0d", i));
        check("burst_end_busy", busy, 0);
        bad = 0;
        repeat (40) begin
            if (tx !== 1'b1) bad++;
            tick;
        end
        check("burst_sixth_dropped", bad, 0);

        // Speed change mid-frame takes effect on the next frame
        data_in = 8'h3C; wr_en = 1'b1; tick;
        data_in = 8'hC3; tick; wr_en = 1'b0;
        speed = 13'd32; set_speed = 1'b1; tick; set_speed = 1'b0;
        check_frame(8'h3C, 16, 10, 1, -1, "spd_old");
        check_frame(8'hC3, 32, 10, 0, -1, "spd_new");
        check("spd_end_busy", busy, 0);

        // Speed below minimum ignored: reset period 6249 remains
        reset = 1'b1; tick; reset = 1'b0;
        speed = 13'd8; set_speed = 1'b1; tick; set_speed = 1'b0;
        data_in = 8'h01; wr_en = 1'b1; tick; wr_en = 1'b0;
        tick;
        check_frame(8'h01, 6249, 2, 0, -1, "slow");
        check("slow_bit1_edge", tx, 0);

        // Reset wins over simultaneous wr_en / set_speed
        reset = 1'b1; wr_en = 1'b1; data_in = 8'h77; set_speed = 1'b1; speed = 13'd16;
        tick;
        reset = 1'b0; wr_en = 1'b0; set_speed = 1'b0;
        check("prio_busy", busy, 0);
        check("prio_tx", tx, 1);
        tick;
        check("prio_busy_later", busy, 0);

        // Reset during data bit 3 with two bytes queued
        speed = 13'd16; set_speed = 1'b1; tick; set_speed = 1'b0;
        data_in = 8'h81; wr_en = 1'b1; tick;
        data_in = 8'h42; tick;
        data_in = 8'h24; tick;
        wr_en = 1'b0;
        repeat (69) tick;
        check("midrst_bit3", tx, 0);
        check("midrst_busy_before", busy, 1);
        reset = 1'b1; tick; reset = 1'b0;
        check("midrst_tx", tx, 1);
        check("midrst_busy", busy, 0);
        check("midrst_full", full, 0);
        check("midrst_txdone", tx_done, 0);
        bad = 0;
        repeat (200) begin
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
            tick;
        end
        check("midrst_quiet", bad, 0);

        // Loopback through reference receiver
        speed = 13'd24; set_speed = 1'b1; tick; set_speed = 1'b0;
        for (int i = 0; i < 3; i++) begin
            data_in = lb[i]; wr_en = 1'b1; tick;
        end
        wr_en = 1'b0;
        inbound = 0;
        for (int i = 0; i < 3; i++) begin
            rx_byte(24, rb, rok);
            check($sformatf("loop_frame%0d", i), rok, 1);
            check($sformatf("loop_data%0d", i), rb, lb[i]);
            if (rok) inbound++;
        end
        bad = 0;
        repeat (300) begin
            if (tx !== 1'b1) bad++;
            tick;
        end
        check("loop_no_extra", bad, 0);
        check("loop_inbound", inbound, 3);
        check("loop_busy", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
